div_unit: RTL



---
 rtl/div_pkg.sv | 40 ++++
 rtl/div_step.sv | 42 ++++
 rtl/div_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : div_pkg                                                |
// | Description : Shared types and constants for the iterative RV32M     |
// |               divide/remainder unit (opcode and FSM state encodings, |
// |               iteration count, signed-overflow operand patterns).    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package div_pkg;

   localparam int DIV_XLEN = 32;
   localparam int DIV_ITER = DIV_XLEN;

   // Operand pair whose signed quotient does not fit in XLEN bits.
   localparam logic [DIV_XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
   localparam logic [DIV_XLEN-1:0] DIV_OVF_DIVISOR  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      OP_DIV  = 2'd0,
      OP_DIVU = 2'd1,
      OP_REM  = 2'd2,
      OP_REMU = 2'd3
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   function automatic logic op_is_signed(div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_rem(div_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : div_step                                               |
// | Description : One radix-2 restoring division iteration, purely       |
// |               combinational: shift {rem,quo} left one bit, trial-    |
// |               subtract the divisor, keep the difference and set the  |
// |               new quotient bit when it does not go negative.         |
// | Ports       : rem_i      partial remainder (always < divisor_i)      |
// |               quo_i      dividend bits still to shift in / quotient  |
// |               divisor_i  unsigned divisor magnitude                  |
// |               next_rem_o partial remainder after this step           |
// |               next_quo_o quotient/dividend register after this step  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] next_rem_o,
   output logic [XLEN-1:0] next_quo_o
);

   logic [XLEN:0] w_rem_sh;
   logic [XLEN:0] w_diff;
   logic          w_fits;

   // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
   assign w_rem_sh = {rem_i, quo_i[XLEN-1]};

   // Trial subtract on the low XLEN bits. If the shifted-out top bit is
   // set the true value already exceeds any divisor, so the subtraction
   // always succeeds and the modular low bits are the exact difference.
   assign w_diff = {1'b0, w_rem_sh[XLEN-1:0]} - {1'b0, divisor_i};
   assign w_fits = w_rem_sh[XLEN] | ~w_diff[XLEN];

   assign next_rem_o = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
   assign next_quo_o = {quo_i[XLEN-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : div_unit                                               |
// | Description : Iterative RV32M DIV/DIVU/REM/REMU unit. Operands are   |
// |               reduced to magnitudes on issue, divided one bit per    |
// |               cycle by div_step, and sign-corrected in DONE.         |
// |               Divide by zero and signed overflow produce the RISC-V  |
// |               defined results without trapping.                      |
// | Ports       : clk, reset (async, active-high)                        |
// |               start/op/dividend/divisor/rd_in : issue, IDLE only     |
// |               flush     : synchronous kill of the operation          |
// |               busy      : unit occupied (state != IDLE)              |
// |               valid_out : one-cycle result strobe                    |
// |               result/rd_out : result and tag, qualified by valid_out |
// | Options     : DIV_FAST_PATH_EN - when defined, divide-by-zero and    |
// |               signed overflow skip the iteration loop (IDLE->DONE).  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module div_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [XLEN-1:0]  dividend,
   input  logic [XLEN-1:0]  divisor,
   input  logic [TAG_W-1:0] rd_in,
   input  logic             flush,
   output logic             busy,
   output logic             valid_out,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] rd_out
);

   import div_pkg::*;

   localparam int c_cnt_w = $clog2(XLEN);

   div_state_e         state_q, state_d;
   div_op_e            op_q, op_d;
   logic [TAG_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]    rem_q, rem_d;
   logic [XLEN-1:0]    quo_q, quo_d;
   logic [XLEN-1:0]    dvs_q, dvs_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic [TAG_W-1:0]   rd_out_q, rd_out_d;

   div_op_e         w_op;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic            w_div_zero;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic [XLEN-1:0] w_next_rem;
   logic [XLEN-1:0] w_next_quo;
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;
   logic [XLEN-1:0] w_res;
   logic            w_valid;

   // ---------------- issue-side operand conditioning ----------------
   assign w_op       = div_op_e'(op);
   assign w_signed   = op_is_signed(w_op);
   assign w_a_neg    = w_signed & dividend[XLEN-1];
   assign w_b_neg    = w_signed & divisor[XLEN-1];
   assign w_div_zero = (divisor == '0);
   assign w_abs_a    = w_a_neg ? -dividend : dividend;
   assign w_abs_b    = w_b_neg ? -divisor  : divisor;

`ifdef DIV_FAST_PATH_EN
   localparam logic [XLEN-1:0] c_ovf_dividend = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] c_ovf_divisor  = {XLEN{1'b1}};
   logic w_ovf;
   assign w_ovf = w_signed && (dividend == c_ovf_dividend) && (divisor == c_ovf_divisor);
`endif

   // ---------------- iteration datapath ----------------
   div_step #(
      .XLEN(XLEN)
   ) u_step (
      .rem_i      (rem_q),
      .quo_i      (quo_q),
      .divisor_i  (dvs_q),
      .next_rem_o (w_next_rem),
      .next_quo_o (w_next_quo)
   );

   // ---------------- sign correction ----------------
   assign w_quo_fix = q_neg_q ? -quo_q : quo_q;
   assign w_rem_fix = r_neg_q ? -rem_q : rem_q;
   assign w_res     = op_is_rem(op_q) ? w_rem_fix : w_quo_fix;

   // ---------------- FSM: next state and datapath ----------------
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      w_valid  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d    = w_op;
               rd_d    = rd_in;
               rem_d   = '0;
               quo_d   = w_abs_a;
               dvs_d   = w_abs_b;
               cnt_d   = c_cnt_w'(XLEN - 1);
               // With a zero divisor the loop already yields all-ones,
               // which must not be negated; the remainder still takes the
               // dividend's sign so it comes back as the dividend itself.
               q_neg_d = (w_a_neg ^ w_b_neg) & ~w_div_zero;
               r_neg_d = w_a_neg;
               state_d = CALC;
`ifdef DIV_FAST_PATH_EN
               if (w_div_zero || w_ovf) begin
                  // Preload the magnitudes the loop would have produced.
                  cnt_d   = '0;
                  state_d = DONE;
                  if (w_div_zero) begin
                     quo_d = '1;
                     rem_d = w_abs_a;
                  end else begin
                     quo_d = w_abs_a;
                     rem_d = '0;
                  end
               end
`endif
            end
         end

         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               rem_d = w_next_rem;
               quo_d = w_next_quo;
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            if (!flush) begin
               w_valid  = 1'b1;
               result_d = w_res;
               rd_out_d = rd_q;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= OP_DIV;
         rd_q     <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   // ---------------- outputs ----------------
   // The result is presented during the DONE cycle itself and then held
   // in result_q/rd_out_q until the next completion.
   assign busy      = (state_q != IDLE);
   assign valid_out = w_valid;
   assign result    = w_valid ? w_res : result_q;
   assign rd_out    = w_valid ? rd_q  : rd_out_q;

endmodule
`default_nettype wire
